instr_encoder: RTL and testbench
================================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, all state on rising edge.
REQ-002 SHALL have port: Reset_n  in  1  asynchronous active-low reset.
REQ-003 SHALL have port: start  in  1  pulse, IDLE->RUN.
REQ-004 SHALL have port: clr  in  1  synchronous abort, returns to IDLE, address to 0.
REQ-005 SHALL have ports: in_valid in 1, in_ready out 1  token handshake; transfer when both high at rising edge.
REQ-006 SHALL have ports: in_op in 4 (mnemonic), in_rs in 5, in_rd in 5, in_rt in 5, in_func in 6, in_imm in 16.
REQ-007 SHALL have ports: im_WrEn out 1, im_Addr out 10, im_WrData out 32  instruction-memory word write port.
REQ-008 SHALL have ports: word_cnt out 11 (words written), done out 1 (FULL), err out 1 (ERR).

Function
REQ-009 SHALL implement FSM IDLE, RUN, FULL, ERR; IDLE->RUN on start; RUN->FULL on write to address 1023; RUN->ERR on illegal in_op accept; FULL, ERR exit only via clr or reset.
REQ-010 SHALL drive in_ready = (state==RUN) && !clr, combinationally.
REQ-011 SHALL map in_op: 0 nop, 1 R-type, 2 li, 3 lui, 4 addi, 5 andi, 6 ori, 7 b, 8 beq, 9 bne, 10 lb, 11 sb, 12 lw, 13 sw; 14-15 illegal.
REQ-012 SHALL encode opcodes [31:26]: R 100000, li 111000, lui 111001, addi 110000, andi 110010, ori 110011, b 111111, beq 000000, bne 000001, lb 000011, sb 000111, lw 001111, sw 011111.
REQ-013 SHALL encode R-type as {100000, rs, rd, rt, 5'b0, func}; all others as {opcode, rs, rd, imm}; nop as 32'h0.
REQ-014 SHALL ignore in_rt/in_func for non-R ops and in_imm for R-type.
REQ-015 SHALL register the write: token accepted at edge k -> im_WrEn=1 with im_Addr/im_WrData valid for exactly the cycle after edge k; im_WrEn=0 otherwise.
REQ-016 SHALL increment the 10-bit address after each write; SHALL NOT wrap (FULL blocks further accepts).
REQ-017 SHALL increment word_cnt per write, max 1024.
REQ-018 SHALL on clr (any state) go IDLE, zero address and word_cnt, deassert err/done next edge; clr with start same cycle: clr wins.
REQ-019 SHALL allow back-to-back accepts at one word per cycle.
REQ-020 SHALL accept beq with rs=rd=imm=0 and write 32'h0 (identical to nop, no error).

Reset
REQ-021 SHALL on Reset_n low, immediately: state IDLE, in_ready 0, im_WrEn 0, im_Addr 0, im_WrData 0, word_cnt 0, done 0, err 0.
REQ-022 SHALL on reset mid-write drop the pending write; no write after Reset_n release until a new accept.

Configuration
REQ-023 SHALL use macro INSTR_ENC_ILLEGAL_CHECK_EN.
REQ-024 SHALL with macro defined: illegal in_op accepted -> no write, state ERR, err=1 next edge.
REQ-025 SHALL without macro: illegal in_op encoded and written as 32'h0 (nop), ERR state unreachable, err tied 0.

Verification
REQ-026 SHALL cover: reset, start, accept op=4 rs=1 rd=2 imm=16'h0005 -> next cycle im_WrEn=1, im_Addr=0, im_WrData=32'hC0220005, word_cnt=1.
REQ-027 SHALL cover: op=1 rs=3 rd=4 rt=5 func=6'h30 -> im_WrData=32'h80642830.
REQ-028 SHALL cover: 1024 back-to-back tokens -> last write im_Addr=1023, done=1, in_ready=0, word_cnt=1024, no 1025th write.
REQ-029 SHALL cover: macro defined, op=15 -> no write, err=1, in_ready=0; clr -> IDLE, err=0, address 0; macro undefined -> 32'h0 written.
REQ-030 SHALL cover: Reset_n low the cycle after an accept -> im_WrEn 0 immediately, all outputs 0, no write after release.
REQ-031 SHALL cover: clr and start high together in IDLE -> stays IDLE, in_ready 0.

Source files
------------

// File: rtl/instr_encoder.sv
// ---------------------------------------------------------------------------
// instr_encoder
//
// Turns a stream of mnemonic instruction tokens into 32-bit machine words
// and writes them, one word per cycle, into consecutive addresses of an
// instruction memory. Writing starts at address 0 and stops at 1023.
//
// Control FSM:
//   IDLE -- start --> RUN
//   RUN  -- write to address 1023 --> FULL
//   RUN  -- illegal in_op accepted --> ERR (only if the check is enabled)
//   FULL and ERR are left only through clr or Reset_n.
//
// Optional feature macro: INSTR_ENC_ILLEGAL_CHECK_EN
//   defined   : an accepted illegal in_op (14, 15) writes nothing, and the
//               block enters ERR with err=1.
//   undefined : an illegal in_op is written as a nop (32'h0). ERR cannot
//               be reached and err is tied to 0.
//
// Ports:
//   clk          in   rising-edge clock for all state
//   Reset_n      in   asynchronous active-low reset
//   start        in   pulse, moves IDLE -> RUN
//   clr          in   synchronous abort: back to IDLE, address and count to 0
//   in_valid     in   token valid
//   in_ready     out  token ready; a token transfers when both are high
//   in_op[3:0]   in   mnemonic selector (0 nop .. 13 sw, 14-15 illegal)
//   in_rs/rd/rt  in   5-bit register fields
//   in_func[5:0] in   R-type function field
//   in_imm[15:0] in   immediate field for non-R ops
//   im_WrEn      out  instruction-memory write strobe (one cycle per word)
//   im_Addr[9:0] out  write address
//   im_WrData    out  encoded 32-bit word
//   word_cnt     out  number of words written since reset/clr (0..1024)
//   done         out  high while in FULL
//   err          out  high while in ERR
// ---------------------------------------------------------------------------
module instr_encoder (
  input  logic        clk,
  input  logic        Reset_n,
  input  logic        start,
  input  logic        clr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_op,
  input  logic [4:0]  in_rs,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rt,
  input  logic [5:0]  in_func,
  input  logic [15:0] in_imm,
  output logic        im_WrEn,
  output logic [9:0]  im_Addr,
  output logic [31:0] im_WrData,
  output logic [10:0] word_cnt,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FULL = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  // Mnemonic codes carried on in_op.
  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_R    = 4'd1,
    OP_LI   = 4'd2,
    OP_LUI  = 4'd3,
    OP_ADDI = 4'd4,
    OP_ANDI = 4'd5,
    OP_ORI  = 4'd6,
    OP_B    = 4'd7,
    OP_BEQ  = 4'd8,
    OP_BNE  = 4'd9,
    OP_LB   = 4'd10,
    OP_SB   = 4'd11,
    OP_LW   = 4'd12,
    OP_SW   = 4'd13
  } mnem_t;

  localparam logic [9:0] LAST_ADDR = 10'd1023;

  state_t      state;
  state_t      state_nxt;
  logic [9:0]  addr;       // next address to be written
  logic        accept;     // token handshake completes this cycle
  logic        wr_fire;    // accepted token produces a memory write
  logic        legal;      // in_op is one of the 14 defined mnemonics
  logic        is_nop;
  logic        is_rtype;
  logic [5:0]  opcode;
  logic [31:0] enc_word;

  // -------------------------------------------------------------------------
  // Handshake. Ready is combinational so clr masks it in the same cycle and
  // no token can slip in while the block is being aborted.
  // -------------------------------------------------------------------------
  assign in_ready = (state == S_RUN) && !clr;
  assign accept   = in_valid && in_ready;

`ifdef INSTR_ENC_ILLEGAL_CHECK_EN
  assign wr_fire  = accept && legal;
`else
  assign wr_fire  = accept;
`endif

  // -------------------------------------------------------------------------
  // Opcode lookup.
  // NOTE: every signal of an always_comb block gets a default before the
  // case statement, so no path leaves it unassigned and no latch is inferred.
  // -------------------------------------------------------------------------
  always_comb begin
    opcode   = 6'b000000;
    legal    = 1'b1;
    is_nop   = 1'b0;
    is_rtype = 1'b0;
    case (in_op)
      OP_NOP:  is_nop   = 1'b1;
      OP_R: begin
        is_rtype = 1'b1;
        opcode   = 6'b100000;
      end
      OP_LI:   opcode = 6'b111000;
      OP_LUI:  opcode = 6'b111001;
      OP_ADDI: opcode = 6'b110000;
      OP_ANDI: opcode = 6'b110010;
      OP_ORI:  opcode = 6'b110011;
      OP_B:    opcode = 6'b111111;
      OP_BEQ:  opcode = 6'b000000;
      OP_BNE:  opcode = 6'b000001;
      OP_LB:   opcode = 6'b000011;
      OP_SB:   opcode = 6'b000111;
      OP_LW:   opcode = 6'b001111;
      OP_SW:   opcode = 6'b011111;
      default: legal  = 1'b0;
    endcase
  end

  // Word assembly. R-type puts rt/func in the low half and ignores in_imm;
  // every other format ignores rt/func. An illegal op falls back to a nop
  // word, which is what gets written when the illegal check is compiled out.
  always_comb begin
    if (is_nop || !legal) begin
      enc_word = 32'h0000_0000;
    end else if (is_rtype) begin
      enc_word = {opcode, in_rs, in_rd, in_rt, 5'b00000, in_func};
    end else begin
      enc_word = {opcode, in_rs, in_rd, in_imm};
    end
  end

  // -------------------------------------------------------------------------
  // Control FSM: state register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the edge, independent of statement order.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Control FSM: next-state logic. clr has priority over everything,
  // including a start in the same cycle.
  always_comb begin
    state_nxt = state;
    if (clr) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state_nxt = S_RUN;
          end
        end
        S_RUN: begin
          // The word going to the last address fills the memory; since the
          // address never wraps, FULL is what stops a 1025th write.
          if (wr_fire && (addr == LAST_ADDR)) begin
            state_nxt = S_FULL;
          end
`ifdef INSTR_ENC_ILLEGAL_CHECK_EN
          if (accept && !legal) begin
            state_nxt = S_ERR;
          end
`endif
        end
        S_FULL:  state_nxt = S_FULL;
        S_ERR:   state_nxt = S_ERR;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Write port and counters. The write is registered: a token accepted at
  // one edge appears on the memory port for exactly the following cycle.
  // Reset clears the strobe asynchronously, so a write in flight when
  // Reset_n falls is dropped.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      im_WrEn   <= 1'b0;
      im_Addr   <= 10'd0;
      im_WrData <= 32'h0000_0000;
      addr      <= 10'd0;
      word_cnt  <= 11'd0;
    end else begin
      im_WrEn <= 1'b0;
      if (clr) begin
        im_Addr   <= 10'd0;
        im_WrData <= 32'h0000_0000;
        addr      <= 10'd0;
        word_cnt  <= 11'd0;
      end else if (wr_fire) begin
        im_WrEn   <= 1'b1;
        im_Addr   <= addr;
        im_WrData <= enc_word;
        // After address 1023 this rolls to 0, but FULL blocks any further
        // accept, so the rolled value is never used for a write.
        addr      <= addr + 10'd1;
        word_cnt  <= word_cnt + 11'd1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Status outputs decoded straight from the state register.
  // -------------------------------------------------------------------------
  assign done = (state == S_FULL);

`ifdef INSTR_ENC_ILLEGAL_CHECK_EN
  assign err = (state == S_ERR);
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// ---------------------------------------------------------------------------
// tb_instr_encoder
//
// Self-checking bench for instr_encoder. A behavioural model tracks the
// block as "running / full / errored" flags plus a count of words written;
// it encodes tokens straight from the mnemonic -> opcode table. Known-answer
// vectors, a fill-to-1024 run, illegal-op, clr/start and mid-write reset
// sequences, and a randomized phase are all compared cycle by cycle.
// Honours INSTR_ENC_ILLEGAL_CHECK_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_instr_encoder;

`ifdef INSTR_ENC_ILLEGAL_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  logic        clk;
  logic        Reset_n;
  logic        start;
  logic        clr;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [4:0]  in_rs;
  logic [4:0]  in_rd;
  logic [4:0]  in_rt;
  logic [5:0]  in_func;
  logic [15:0] in_imm;
  logic        im_WrEn;
  logic [9:0]  im_Addr;
  logic [31:0] im_WrData;
  logic [10:0] word_cnt;
  logic        done;
  logic        err;

  instr_encoder dut (
    .clk       (clk),
    .Reset_n   (Reset_n),
    .start     (start),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_rs     (in_rs),
    .in_rd     (in_rd),
    .in_rt     (in_rt),
    .in_func   (in_func),
    .in_imm    (in_imm),
    .im_WrEn   (im_WrEn),
    .im_Addr   (im_Addr),
    .im_WrData (im_WrData),
    .word_cnt  (word_cnt),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- counters and check ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Opcode per mnemonic; entries 0 (nop) and 1 (R-type) are special-cased.
  logic [5:0] opc_tab [0:13] = '{6'b000000, 6'b100000, 6'b111000, 6'b111001,
                                 6'b110000, 6'b110010, 6'b110011, 6'b111111,
                                 6'b000000, 6'b000001, 6'b000011, 6'b000111,
                                 6'b001111, 6'b011111};

  function automatic logic [31:0] ref_word(input logic [3:0] op, input logic [4:0] rs,
                                           input logic [4:0] rd, input logic [4:0] rt,
                                           input logic [5:0] fn, input logic [15:0] imm);
    if (op == 4'd1) return {6'b100000, rs, rd, rt, 5'b00000, fn};
    if (op == 4'd0 || op > 4'd13) return 32'h0;
    return {opc_tab[op], rs, rd, imm};
  endfunction

  bit          m_run, m_full, m_err;
  int          m_cnt;
  bit          exp_wren;
  logic [31:0] exp_addr, exp_data;

  task automatic model_reset();
    m_run = 0; m_full = 0; m_err = 0; m_cnt = 0; exp_wren = 0;
  endtask

  // One clock cycle: check ready before the edge, advance the model at the
  // edge, compare the registered outputs just after it.
  task automatic cycle();
    bit          rdy, acc, bad;
    logic [31:0] w;
    @(negedge clk);
    rdy = m_run && !clr;
    check("in_ready", {31'b0, in_ready}, {31'b0, rdy});
    acc = in_valid && rdy;
    bad = (in_op > 4'd13);
    w   = ref_word(in_op, in_rs, in_rd, in_rt, in_func, in_imm);
    @(posedge clk);
    #1;
    exp_wren = 0;
    if (clr) begin
      m_run = 0; m_full = 0; m_err = 0; m_cnt = 0;
    end else if (!m_run && !m_full && !m_err) begin
      if (start) m_run = 1;
    end else if (acc) begin
      if (bad && CHECK_EN) begin
        m_run = 0; m_err = 1;
      end else begin
        exp_wren = 1;
        exp_addr = 32'(m_cnt);
        exp_data = w;
        m_cnt++;
        if (m_cnt == 1024) begin
          m_run = 0; m_full = 1;
        end
      end
    end
    check("im_WrEn", {31'b0, im_WrEn}, {31'b0, exp_wren});
    if (exp_wren) begin
      check("im_Addr", {22'b0, im_Addr}, exp_addr);
      check("im_WrData", im_WrData, exp_data);
    end
    check("word_cnt", {21'b0, word_cnt}, 32'(m_cnt));
    check("done", {31'b0, done}, {31'b0, m_full});
    check("err", {31'b0, err}, {31'b0, m_err});
  endtask

  task automatic quiet();
    start = 0; clr = 0; in_valid = 0;
    in_op = 0; in_rs = 0; in_rd = 0; in_rt = 0; in_func = 0; in_imm = 0;
  endtask

  task automatic do_clr();
    quiet(); clr = 1; cycle(); clr = 0;
  endtask

  task automatic do_start();
    quiet(); start = 1; cycle(); start = 0;
  endtask

  task automatic token(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rd,
                       input logic [4:0] rt, input logic [5:0] fn, input logic [15:0] imm);
    in_valid = 1; in_op = op; in_rs = rs; in_rd = rd; in_rt = rt; in_func = fn; in_imm = imm;
  endtask

  // ---------------- known-answer vectors ----------------
  typedef struct {
    logic [3:0]  op;
    logic [4:0]  rs, rd, rt;
    logic [5:0]  fn;
    logic [15:0] imm;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int writes;
    logic [9:0] last_addr;
    logic [31:0] ill_data;

    vecs[0] = '{4'd4,  5'd1,  5'd2,  5'd0,  6'h00, 16'h0005, 32'hC022_0005}; // addi
    vecs[1] = '{4'd1,  5'd3,  5'd4,  5'd5,  6'h30, 16'hFFFF, 32'h8064_2830}; // R, imm ignored
    vecs[2] = '{4'd0,  5'd31, 5'd31, 5'd31, 6'h3F, 16'hFFFF, 32'h0000_0000}; // nop
    vecs[3] = '{4'd8,  5'd0,  5'd0,  5'd7,  6'h11, 16'h0000, 32'h0000_0000}; // beq all-zero
    vecs[4] = '{4'd3,  5'd0,  5'd5,  5'd9,  6'h2A, 16'h1234, 32'hE405_1234}; // lui, rt/func ignored
    vecs[5] = '{4'd13, 5'd31, 5'd0,  5'd0,  6'h00, 16'h0000, 32'h7FE0_0000}; // sw
    vecs[6] = '{4'd7,  5'd0,  5'd0,  5'd0,  6'h00, 16'hABCD, 32'hFC00_ABCD}; // b
    vecs[7] = '{4'd2,  5'd1,  5'd1,  5'd0,  6'h00, 16'h0000, 32'hE021_0000}; // li

    // ---- reset state ----
    Reset_n = 0;
    quiet();
    model_reset();
    #3;
    check("rst in_ready", {31'b0, in_ready}, 32'd0);
    check("rst im_WrEn", {31'b0, im_WrEn}, 32'd0);
    check("rst im_Addr", {22'b0, im_Addr}, 32'd0);
    check("rst im_WrData", im_WrData, 32'd0);
    check("rst word_cnt", {21'b0, word_cnt}, 32'd0);
    check("rst done", {31'b0, done}, 32'd0);
    check("rst err", {31'b0, err}, 32'd0);
    @(posedge clk);
    #1;
    Reset_n = 1;

    // ---- known-answer vectors, back to back ----
    do_start();
    for (int i = 0; i < 8; i++) begin
      token(vecs[i].op, vecs[i].rs, vecs[i].rd, vecs[i].rt, vecs[i].fn, vecs[i].imm);
      cycle();
      check($sformatf("vec%0d word", i), im_WrData, vecs[i].exp);
      check($sformatf("vec%0d addr", i), {22'b0, im_Addr}, 32'(i));
    end
    quiet();
    cycle();
    check("idle after vecs im_WrEn", {31'b0, im_WrEn}, 32'd0);
    check("vec word_cnt", {21'b0, word_cnt}, 32'd8);

    // ---- clr and start together in IDLE: clr wins ----
    do_clr();
    quiet(); clr = 1; start = 1; cycle();
    quiet(); in_valid = 1; in_op = 4'd4;
    cycle();
    check("clr+start in_ready", {31'b0, in_ready}, 32'd0);
    check("clr+start word_cnt", {21'b0, word_cnt}, 32'd0);

    // ---- illegal op ----
    do_clr();
    do_start();
    token(4'd15, 5'd3, 5'd3, 5'd3, 6'h3F, 16'hBEEF);
    cycle();
    ill_data = im_WrData;
    quiet();
    cycle();
    if (CHECK_EN) begin
      check("illegal err", {31'b0, err}, 32'd1);
      check("illegal in_ready", {31'b0, in_ready}, 32'd0);
      check("illegal word_cnt", {21'b0, word_cnt}, 32'd0);
    end else begin
      check("illegal as nop data", ill_data, 32'd0);
      check("illegal as nop word_cnt", {21'b0, word_cnt}, 32'd1);
      check("illegal err tied", {31'b0, err}, 32'd0);
    end
    do_clr();
    check("after clr err", {31'b0, err}, 32'd0);
    check("after clr in_ready", {31'b0, in_ready}, 32'd0);
    do_start();
    token(4'd12, 5'd2, 5'd9, 5'd0, 6'h00, 16'h0040);
    cycle();
    check("after clr im_Addr", {22'b0, im_Addr}, 32'd0);
    check("after clr lw word", im_WrData, 32'h3C49_0040);

    // ---- reset one cycle after an accept ----
    token(4'd5, 5'd4, 5'd4, 5'd0, 6'h00, 16'h00FF);
    cycle();
    check("pre-reset im_WrEn", {31'b0, im_WrEn}, 32'd1);
    #1 Reset_n = 0;
    #1;
    check("mid rst im_WrEn", {31'b0, im_WrEn}, 32'd0);
    check("mid rst im_Addr", {22'b0, im_Addr}, 32'd0);
    check("mid rst im_WrData", im_WrData, 32'd0);
    check("mid rst word_cnt", {21'b0, word_cnt}, 32'd0);
    check("mid rst in_ready", {31'b0, in_ready}, 32'd0);
    check("mid rst done/err", {30'b0, done, err}, 32'd0);
    #1 Reset_n = 1;
    model_reset();
    token(4'd4, 5'd1, 5'd1, 5'd0, 6'h00, 16'h0001);
    for (int i = 0; i < 3; i++) cycle();

    // ---- fill all 1024 words back to back ----
    do_clr();
    do_start();
    writes = 0;
    last_addr = '0;
    for (int i = 0; i < 1030; i++) begin
      token(4'($urandom_range(0, 13)), 5'($urandom), 5'($urandom), 5'($urandom),
            6'($urandom), 16'($urandom));
      cycle();
      if (im_WrEn) begin
        writes++;
        last_addr = im_Addr;
      end
    end
    quiet();
    check("full write count", 32'(writes), 32'd1024);
    check("full last addr", {22'b0, last_addr}, 32'd1023);
    check("full done", {31'b0, done}, 32'd1);
    check("full word_cnt", {21'b0, word_cnt}, 32'd1024);
    check("full in_ready", {31'b0, in_ready}, 32'd0);

    // ---- randomized traffic ----
    do_clr();
    for (int i = 0; i < 400; i++) begin
      start    = ($urandom_range(0, 3) == 0);
      clr      = ($urandom_range(0, 24) == 0);
      in_valid = ($urandom_range(0, 3) != 0);
      in_op    = 4'($urandom);
      in_rs    = 5'($urandom);
      in_rd    = 5'($urandom);
      in_rt    = 5'($urandom);
      in_func  = 6'($urandom);
      in_imm   = 16'($urandom);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
